// File: rtl/foc_scheduler.sv
// foc_scheduler: periodic sequencer for the FOC control loop.
// Generates the control-period tick, requests a sensor sample, launches one
// loop iteration over valid/ready, then measures latency and counts overruns.
// Optional watchdog that aborts hung iterations: define FOC_SCHED_WATCHDOG_EN.
module foc_scheduler #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rstb,
  input  logic                 i_enable,
  input  logic [CNT_WIDTH-1:0] i_period,
  input  logic [CNT_WIDTH-1:0] i_timeout,
  input  logic                 i_clear_fault,
  output logic                 o_sample_req,
  input  logic                 i_sample_ack,
  output logic                 o_loop_valid,
  input  logic                 i_loop_ready,
  output logic                 o_loop_abort,
  output logic                 o_busy,
  output logic                 o_loop_done,
  output logic [CNT_WIDTH-1:0] o_last_latency,
  output logic                 o_overrun,
  output logic [CNT_WIDTH-1:0] o_overrun_cnt,
  output logic                 o_fault
);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_TWO = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SAMPLE, S_LAUNCH, S_BUSY, S_FAULT
  } state_t;

  state_t               r_state, w_state_n;
  logic [CNT_WIDTH-1:0] r_pcnt, r_period, w_period_eff, w_period_cur;
  logic                 r_pvalid, r_tick, w_wrap;
  logic                 r_seen_low, r_cpl;
  logic [CNT_WIDTH-1:0] r_lat, r_last_lat, r_ovr_cnt;
  logic                 r_sample_req, r_loop_valid, r_busy, r_loop_done, r_overrun;
  logic                 w_launch, w_complete, w_expire, w_overrun, w_busy_n;

  // Periods below 2 would make the wrap compare degenerate, so clamp to 2.
  assign w_period_eff = (i_period < C_TWO) ? C_TWO : i_period;
  // Right after enable (or reset) nothing is latched yet; use the live value.
  assign w_period_cur = r_pvalid ? r_period : w_period_eff;
  assign w_wrap       = (r_pcnt == w_period_cur - C_ONE);

  // Period counter: tick is registered on the wrap edge, period reloads at wrap.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_pcnt   <= '0;
      r_period <= C_TWO;
      r_pvalid <= 1'b0;
      r_tick   <= 1'b0;
    end else if (!i_enable) begin
      r_pcnt   <= '0;
      r_period <= w_period_eff;
      r_pvalid <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_pvalid <= 1'b1;
      r_tick   <= w_wrap;
      if (w_wrap) begin
        r_pcnt   <= '0;
        r_period <= w_period_eff;
      end else begin
        r_pcnt <= r_pcnt + C_ONE;
        if (!r_pvalid) r_period <= w_period_eff;
      end
    end
  end

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    w_state_n  = r_state;
    w_launch   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE:   if (i_enable && !o_fault) w_state_n = S_WAIT;
      S_WAIT:   if (!i_enable) w_state_n = S_IDLE;
                else if (r_tick) w_state_n = S_SAMPLE;
      S_SAMPLE: if (i_sample_ack) w_state_n = S_LAUNCH;
      S_LAUNCH: if (i_loop_ready) begin
                  w_launch  = 1'b1;
                  w_state_n = S_BUSY;
                end
      S_BUSY:   if (r_cpl) begin
                  w_complete = 1'b1;
                  w_state_n  = i_enable ? S_WAIT : S_IDLE;
                end else if (w_expire) begin
                  w_state_n = S_FAULT;
                end
`ifdef FOC_SCHED_WATCHDOG_EN
      S_FAULT:  if (i_clear_fault) w_state_n = S_IDLE;
`endif
      default:  w_state_n = S_IDLE;
    endcase
  end

  // A tick that finds an iteration still in flight is dropped, never queued.
  assign w_overrun = r_tick && (r_state inside {S_SAMPLE, S_LAUNCH, S_BUSY});
  assign w_busy_n  = (w_state_n inside {S_SAMPLE, S_LAUNCH, S_BUSY});

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // Registered outputs, completion detect (ready low then high) and latency.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_sample_req <= 1'b0;
      r_loop_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_loop_done  <= 1'b0;
      r_overrun    <= 1'b0;
      r_ovr_cnt    <= '0;
      r_last_lat   <= '0;
      r_lat        <= '0;
      r_seen_low   <= 1'b0;
      r_cpl        <= 1'b0;
    end else begin
      r_sample_req <= (w_state_n == S_SAMPLE);
      r_loop_valid <= w_launch;
      r_busy       <= w_busy_n;
      r_loop_done  <= w_complete;
      r_overrun    <= w_overrun;
      if (w_overrun && r_ovr_cnt != C_MAX) r_ovr_cnt <= r_ovr_cnt + C_ONE;
      if (w_launch) begin
        r_seen_low <= 1'b0;
        r_cpl      <= 1'b0;
        r_lat      <= '0;
      end else if (r_state == S_BUSY) begin
        if (!i_loop_ready)              r_seen_low <= 1'b1;
        if (r_seen_low && i_loop_ready) r_cpl      <= 1'b1;
        if (r_lat != C_MAX)             r_lat      <= r_lat + C_ONE;
      end
      if (w_complete) r_last_lat <= r_lat;
    end
  end

`ifdef FOC_SCHED_WATCHDOG_EN
  logic [CNT_WIDTH-1:0] r_wdcnt;
  logic                 r_abort, r_fault;

  // r_wdcnt holds the index of the current BUSY cycle (first BUSY cycle = 1).
  assign w_expire = (r_state == S_BUSY) && !r_cpl && (i_timeout != '0) &&
                    (r_wdcnt == i_timeout);

  // Watchdog counter, abort strobe and sticky fault.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_wdcnt <= '0;
      r_abort <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_abort <= w_expire;
      if (w_launch)                                      r_wdcnt <= C_ONE;
      else if (r_state == S_BUSY && r_wdcnt != C_MAX)    r_wdcnt <= r_wdcnt + C_ONE;
      if (w_expire)                                      r_fault <= 1'b1;
      else if (r_state == S_FAULT && i_clear_fault)      r_fault <= 1'b0;
    end
  end

  assign o_loop_abort = r_abort;
  assign o_fault      = r_fault;
`else
  logic w_unused;
  assign w_expire     = 1'b0;
  assign o_loop_abort = 1'b0;
  assign o_fault      = 1'b0;
  assign w_unused     = ^{i_timeout, i_clear_fault};
`endif

  assign o_sample_req   = r_sample_req;
  assign o_loop_valid   = r_loop_valid;
  assign o_busy         = r_busy;
  assign o_loop_done    = r_loop_done;
  assign o_last_latency = r_last_lat;
  assign o_overrun      = r_overrun;
  assign o_overrun_cnt  = r_ovr_cnt;
endmodule
